// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store RAM master: RAM access modes, RV32I
// load/store funct3 codes, FSM states and funct3 decode helpers.
package lsu_pkg;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10,
    RESP    = 2'b11
  } state_e;

  function automatic logic [1:0] funct3_to_mode(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return MODE_BYTE;
      2'b01:   return MODE_HALF;
      default: return MODE_WORD;
    endcase
  endfunction

  // Stores have no unsigned variants, so any funct3 with bit 2 set is illegal.
  function automatic logic funct3_illegal(input logic store, input logic [2:0] f3);
    if (store) return f3[2] || (f3 == 3'b011);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select and sign/zero extension of a returned RAM word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[8*addr_lo_i +: 8];
    half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data_o = {24'h0, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_HU:   data_o = {16'h0, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_ram_master.sv
// Load/store initiator for the single-port data RAM with a 1-cycle registered read.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses return an error instead of issuing.
module lsu_ram_master
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS = 17
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_write_en,
  output logic [1:0]  ram_mode,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data
);

  state_e      state_q;
  logic        req_ready_q, resp_valid_q, resp_err_q, ram_we_q, store_q;
  logic [31:0] resp_rdata_q, ram_addr_q, ram_wdata_q;
  logic [1:0]  ram_mode_q, addr_lo_q;
  logic [2:0]  funct3_q;

  logic [1:0]  mode_d;
  logic        err_d;
  logic [31:0] load_data;

  always_comb begin
    mode_d = funct3_to_mode(req_funct3);
    err_d  = funct3_illegal(req_store, req_funct3) || (|(req_addr >> ADDR_BITS));
`ifdef MISALIGN_TRAP_EN
    if ((mode_d == MODE_HALF && req_addr[0]) ||
        (mode_d == MODE_WORD && req_addr[1:0] != 2'b00))
      err_d = 1'b1;
`endif
  end

  lsu_load_align u_align (
    .word_i    (ram_read_data),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (load_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      ram_we_q     <= 1'b0;
      ram_mode_q   <= MODE_WORD;
      ram_addr_q   <= 32'h0;
      ram_wdata_q  <= 32'h0;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            if (err_d) begin
              // Rejected requests never touch the RAM; ram_* keep their last value.
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
              state_q      <= RESP;
            end else begin
              ram_we_q    <= req_store;
              ram_mode_q  <= mode_d;
              ram_addr_q  <= req_addr;
              ram_wdata_q <= req_wdata;
              store_q     <= req_store;
              funct3_q    <= req_funct3;
              addr_lo_q   <= req_addr[1:0];
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          ram_we_q <= 1'b0;
          if (store_q) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            state_q      <= RESP;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          resp_rdata_q <= load_data;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;
  assign ram_write_en   = ram_we_q;
  assign ram_mode       = ram_mode_q;
  assign ram_addr       = ram_addr_q;
  assign ram_write_data = ram_wdata_q;

endmodule

// File: tb/tb_lsu_ram_master.sv
// Self-checking bench for lsu_ram_master: directed steps plus random load/store
// traffic checked against a byte-array memory model.
module tb_lsu_ram_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        ram_write_en;
  logic [1:0]  ram_mode;
  logic [31:0] ram_addr, ram_write_data;
  logic [31:0] ram_read_data = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ram_master dut (
    .clk            (clk),
    .rstn           (rstn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_store      (req_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .ram_write_en   (ram_write_en),
    .ram_mode       (ram_mode),
    .ram_addr       (ram_addr),
    .ram_write_data (ram_write_data),
    .ram_read_data  (ram_read_data)
  );

  // Environment RAM: word array, low address bits ignored as the mode dictates.
  logic [31:0] ram [0:32767];
  always @(posedge clk) begin
    if (ram_write_en) begin
      case (ram_mode)
        2'b00:   ram[ram_addr[16:2]][8*ram_addr[1:0] +: 8] <= ram_write_data[7:0];
        2'b01:   ram[ram_addr[16:2]][16*ram_addr[1] +: 16] <= ram_write_data[15:0];
        default: ram[ram_addr[16:2]] <= ram_write_data;
      endcase
    end
    ram_read_data <= ram[ram_addr[16:2]];
  end

  int          we_count = 0;
  logic [1:0]  we_mode;
  logic [31:0] we_addr, we_data;
  always @(posedge clk) begin
    if (ram_write_en) begin
      we_count <= we_count + 1;
      we_mode  <= ram_mode;
      we_addr  <= ram_addr;
      we_data  <= ram_write_data;
    end
  end

  // Reference memory as plain bytes.
  logic [7:0] rmem [0:131071];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit trap_on();
`ifdef MISALIGN_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_error(input logic st, input logic [2:0] f3, input logic [31:0] a);
    bit bad;
    bad = (a[31:17] != 0);
    if (st) bad = bad || (f3 > 3'd2);
    else    bad = bad || (f3 == 3'd3) || (f3 > 3'd5);
    if (trap_on() && f3[1:0] == 2'b01 && a[0]) bad = 1;
    if (trap_on() && f3[1:0] == 2'b10 && a[1:0] != 0) bad = 1;
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int i;
    logic [7:0]  b;
    logic [15:0] h;
    i = int'(a[16:0]);
    case (f3[1:0])
      2'b00: begin
        b = rmem[i];
        return f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        i = i & ~1;
        h = {rmem[i+1], rmem[i]};
        return f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: begin
        i = i & ~3;
        return {rmem[i+3], rmem[i+2], rmem[i+1], rmem[i]};
      end
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int i;
    i = int'(a[16:0]);
    case (f3[1:0])
      2'b00: rmem[i] = wd[7:0];
      2'b01: begin
        i = i & ~1;
        rmem[i] = wd[7:0]; rmem[i+1] = wd[15:8];
      end
      default: begin
        i = i & ~3;
        for (int k = 0; k < 4; k++) rmem[i+k] = wd[8*k +: 8];
      end
    endcase
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
  endtask

  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input string tag);
    bit          err;
    int          exp_lat, lat, we0;
    logic [31:0] exp_rd;
    err     = exp_error(st, f3, a);
    exp_lat = err ? 1 : (st ? 2 : 3);
    exp_rd  = (err || st) ? 32'h0 : model_load(f3, a);
    we0     = we_count;
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'd1);
    drive(st, f3, a, wd);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_resp_err"}, {31'h0, resp_err}, {31'h0, err});
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_writes"}, we_count - we0, (st && !err) ? 1 : 0);
    if (st && !err) begin
      chk({tag, "_ram_mode"}, {30'h0, we_mode}, {30'h0, f3[1:0]});
      chk({tag, "_ram_addr"}, we_addr, a);
      chk({tag, "_ram_wdata"}, we_data, wd);
      model_store(f3, a, wd);
    end
    @(posedge clk); #1;
    chk({tag, "_done_valid"}, {31'h0, resp_valid}, 32'd0);
    chk({tag, "_done_ready"}, {31'h0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, held;
    int          lat;
    for (int i = 0; i < 32768; i++) ram[i] = 32'h0;
    for (int i = 0; i < 131072; i++) rmem[i] = 8'h0;
    rstn = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_we", {31'h0, ram_write_en}, 32'd0);
    chk("rst_mode", {30'h0, ram_mode}, 32'd2);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_wdata", ram_write_data, 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    txn(1, 3'b010, 32'h100, 32'hDEADBEEF, "sw100");
    txn(0, 3'b000, 32'h103, 32'h0, "lb103");
    chk("lb103_const", model_load(3'b000, 32'h103), 32'hFFFFFFDE);
    txn(0, 3'b100, 32'h103, 32'h0, "lbu103");
    txn(0, 3'b001, 32'h102, 32'h0, "lh102");
    txn(0, 3'b010, 32'h100, 32'h0, "lw100");
    txn(1, 3'b000, 32'h101, 32'h12345677, "sb101");
    txn(0, 3'b010, 32'h100, 32'h0, "lw100b");
    chk("lw100b_const", model_load(3'b010, 32'h100), 32'hDEAD77EF);
    txn(0, 3'b010, 32'h0002_0000, 32'h0, "lw_range");
    txn(0, 3'b011, 32'h100, 32'h0, "ld_f3_011");
    txn(1, 3'b011, 32'h100, 32'h5, "st_f3_011");
    txn(1, 3'b100, 32'h100, 32'h5, "st_f3_100");
    txn(0, 3'b110, 32'h100, 32'h0, "ld_f3_110");
    txn(0, 3'b001, 32'h101, 32'h0, "lh101");
    txn(0, 3'b101, 32'h103, 32'h0, "lhu103");

    // Back-pressure: response must hold while resp_ready is low.
    resp_ready = 1'b0;
    drive(0, 3'b010, 32'h100, 32'h0);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_latency", lat, 3);
    held = model_load(3'b010, 32'h100);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'h0, resp_valid}, 32'd1);
      chk("stall_rdata", resp_rdata, held);
      chk("stall_req_ready", {31'h0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {31'h0, resp_valid}, 32'd0);

    // Reset asserted while a store is in ISSUE: the write must never land.
    drive(1, 3'b010, 32'h200, 32'hCAFEF00D);
    chk("rstmid_we_before", {31'h0, ram_write_en}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("rstmid_we", {31'h0, ram_write_en}, 32'd0);
    chk("rstmid_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rstmid_mode", {30'h0, ram_mode}, 32'd2);
    chk("rstmid_addr", ram_addr, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_after_valid", {31'h0, resp_valid}, 32'd0);
    chk("rstmid_after_we", {31'h0, ram_write_en}, 32'd0);
    txn(0, 3'b010, 32'h200, 32'h0, "rstmid_lw200");

    for (int n = 0; n < 60; n++) begin
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(17, 31));
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rnd");
    end
    for (int n = 0; n < 16; n++)
      txn(0, 3'b010, 32'(4 * n), 32'h0, "sweep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
